// File: rtl/demux_lane_pkg.sv
// Shared definitions for the demux lane scheduler: lane count, select type and helpers.
package demux_lane_pkg;

  localparam int unsigned LANES = 4;
  localparam int unsigned SEL_W = 2;

  typedef logic [SEL_W-1:0] lane_sel_t;

  // One-hot decode of a lane select.
  function automatic logic [LANES-1:0] onehot4(lane_sel_t sel);
    logic [LANES-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/lane_picker.sv
// Rotate-priority lane search: first ready lane starting at ptr, else ptr itself.
// Only instantiated when LANE_SKIP_EN is defined.
module lane_picker
  import demux_lane_pkg::*;
(
  input  lane_sel_t        ptr,
  input  logic [LANES-1:0] lane_ready,
  output lane_sel_t        chosen
);

  lane_sel_t cand;

  // Scan from the farthest offset down so the nearest ready lane wins last.
  always_comb begin
    chosen = ptr;
    cand   = ptr;
    for (int i = LANES - 1; i >= 0; i--) begin
      cand = ptr + lane_sel_t'(i);
      if (lane_ready[cand]) begin
        chosen = cand;
      end
    end
  end

endmodule

// File: rtl/demux_lane_sched.sv
// Upstream scheduler for a 1:4 demux: one-entry output register, round-robin lane choice.
// Optional feature: define LANE_SKIP_EN to skip lanes that are not ready when choosing.
module demux_lane_sched
  import demux_lane_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [LANES-1:0]  lane_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output lane_sel_t         out_sel,
  output logic [LANES-1:0]  out_lane_valid,
  output logic [CNT_W-1:0]  word_count
);

  lane_sel_t ptr_q;
  lane_sel_t chosen;
  logic      drain;
  logic      accept;

`ifdef LANE_SKIP_EN
  lane_picker u_lane_picker (
    .ptr        (ptr_q),
    .lane_ready (lane_ready),
    .chosen     (chosen)
  );
`else
  assign chosen = ptr_q;
`endif

  // Handshake: the held word leaves when its lane is ready, freeing the register same cycle.
  always_comb begin
    drain          = out_valid && lane_ready[out_sel];
    in_ready       = !out_valid || lane_ready[out_sel];
    accept         = in_valid && in_ready;
    out_lane_valid = onehot4(out_sel) & {LANES{out_valid}};
  end

  // Output register, lane pointer and accepted-word counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sel    <= '0;
      ptr_q      <= '0;
      word_count <= '0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_data   <= in_data;
      out_sel    <= chosen;
      ptr_q      <= chosen + lane_sel_t'(1);
      word_count <= word_count + CNT_W'(1);
    end else if (drain) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_demux_lane_sched.sv
// Randomized self-checking bench for demux_lane_sched against a word-level reference model.
module tb_demux_lane_sched;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [3:0]        lane_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        out_sel;
  logic [3:0]        out_lane_valid;
  logic [CNT_W-1:0]  word_count;

  demux_lane_sched #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .lane_ready     (lane_ready),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_sel        (out_sel),
    .out_lane_valid (out_lane_valid),
    .word_count     (word_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the word currently held, plus totals over the whole stream.
  bit m_valid;
  int m_data;
  int m_sel;
  int m_total;   // words accepted since reset, unbounded
  int m_ptr;     // next lane to try first (skip mode)

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0;
    m_data  = 0;
    m_sel   = 0;
    m_total = 0;
    m_ptr   = 0;
  endtask

  function automatic int pick_lane(logic [3:0] rdy);
`ifdef LANE_SKIP_EN
    for (int k = 0; k < 4; k++) begin
      if (rdy[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    end
    return m_ptr;
`else
    return m_total % 4;
`endif
  endfunction

  // One clock: inputs are already driven; check at negedge, advance model at posedge.
  task automatic step();
    bit exp_ready;
    bit acc;
    bit drn;
    int lane;
    @(negedge clk);
    exp_ready = !m_valid || lane_ready[m_sel];
    check_eq("in_ready", 32'(in_ready), 32'(exp_ready));
    check_eq("out_valid", 32'(out_valid), 32'(m_valid));
    check_eq("out_lane_valid", 32'(out_lane_valid), m_valid ? (32'd1 << m_sel) : 32'd0);
    check_eq("word_count", 32'(word_count), 32'(m_total % (1 << CNT_W)));
    if (m_valid) begin
      check_eq("out_data", 32'(out_data), 32'(m_data));
      check_eq("out_sel", 32'(out_sel), 32'(m_sel));
    end
    acc  = in_valid && exp_ready;
    drn  = m_valid && lane_ready[m_sel];
    lane = pick_lane(lane_ready);
    @(posedge clk);
    if (acc) begin
      m_valid = 1;
      m_data  = int'(in_data);
      m_sel   = lane;
      m_ptr   = (lane + 1) % 4;
      m_total++;
    end else if (drn) begin
      m_valid = 0;
    end
    #1;
  endtask

  task automatic drive(input bit v, input int d, input logic [3:0] rdy);
    in_valid   = v;
    in_data    = DATA_W'(d);
    lane_ready = rdy;
  endtask

  initial begin
    drive(0, 0, 4'hF);
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data", 32'(out_data), 32'd0);
    check_eq("rst_out_sel", 32'(out_sel), 32'd0);
    check_eq("rst_lane_valid", 32'(out_lane_valid), 32'd0);
    check_eq("rst_word_count", 32'(word_count), 32'd0);
    reset = 1'b0;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);

    // Full-rate stream, all lanes ready: lanes 0,1,2,3,0,1,2,3.
    for (int i = 0; i < 8; i++) begin
      drive(1, 8'h10 + i, 4'hF);
      step();
    end
    drive(0, 0, 4'hF);
    step();
    check_eq("burst_count", 32'(word_count), 32'd8);

    // Lane 1 stalled: second word waits until lane 1 is ready.
    drive(1, 8'hA0, 4'b1101);
    step();
    drive(1, 8'hA1, 4'b1101);
    step();
    drive(1, 8'hA2, 4'b1101);
    for (int i = 0; i < 4; i++) step();
    drive(0, 0, 4'b1111);
    step();
    step();

    // Randomized traffic with biased lane readiness.
    for (int i = 0; i < 400; i++) begin
      logic [3:0] rdy;
      rdy = 4'($urandom);
      if ($urandom_range(0, 3) == 0) rdy = 4'hF;
      drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)), rdy);
      step();
    end

    // Mid-stream asynchronous reset while a word is held.
    drive(1, 8'h5A, 4'h0);
    step();
    drive(0, 0, 4'h0);
    step();
    check_eq("pre_rst_valid", 32'(out_valid), 32'd1);
    reset = 1'b1;
    #2;
    check_eq("async_out_valid", 32'(out_valid), 32'd0);
    check_eq("async_out_data", 32'(out_data), 32'd0);
    check_eq("async_lane_valid", 32'(out_lane_valid), 32'd0);
    check_eq("async_word_count", 32'(word_count), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(1, 8'hE1, 4'hF);
    step();
    drive(0, 0, 4'h0);
    step();
    check_eq("post_rst_sel", 32'(out_sel), 32'd0);
    check_eq("post_rst_data", 32'(out_data), 32'hE1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_lane_sched.md
# demux_lane_sched

Upstream scheduler for the 1:4 demultiplexer stage: accepts a single valid/ready word stream and assigns each word to one of four output lanes, producing the registered data word plus the 2-bit lane select that drive the demux. Holds each word in a one-entry output register until the addressed lane accepts it, so a stalled lane back-pressures the input. Lane choice is round-robin, optionally skipping lanes that are not ready.

## Interface
- DATA_W, 8, width of the data word
- CNT_W, 16, width of the accepted-word counter
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  input word present
- in_data  in  DATA_W  input word
- in_ready  out  1  scheduler can accept this cycle
- lane_ready  in  4  per-lane ready from downstream consumers; bit n = lane n
- out_valid  out  1  output register holds a word
- out_data  out  DATA_W  word to demux data input
- out_sel  out  2  lane select to demux sel
- out_lane_valid  out  4  one-hot of out_sel when out_valid, else 0
- word_count  out  CNT_W  number of words accepted since reset

## Operation
- Clocking fixed: one clock; reset is asynchronous and active-high, ports clk and reset.
- Reset values: out_valid=0, out_data=0, out_sel=0, out_lane_valid=0, word_count=0, internal lane pointer ptr=0; in_ready=1 after reset deasserts.
- Drain: word leaves when out_valid && lane_ready[out_sel]; out_valid clears next edge unless a new word is accepted in the same cycle.
- in_ready = !out_valid || lane_ready[out_sel] (combinational; supports back-to-back at full rate).
- Accept: in_valid && in_ready. On accept, out_data<=in_data, out_valid<=1, out_sel<=chosen lane, word_count<=word_count+1 (wraps modulo 2^CNT_W).
- Lane choice (strict): chosen=ptr; ptr<=ptr+1 mod 4 on each accept.
- Lane choice (skip, see Configuration): chosen = first lane n in order ptr, ptr+1, ptr+2, ptr+3 (mod 4) with lane_ready[n]=1 in the accept cycle; if none ready, chosen=ptr. ptr<=chosen+1 mod 4.
- ptr changes only on accept; no accept means no change.
- Simultaneous drain and accept: old word leaves, new word loaded, out_valid stays 1.
- Data and sel in the output register are never altered while out_valid && !lane_ready[out_sel].
- Reset mid-transfer: held word dropped, ptr and counter cleared immediately.

## Timing
- Latency: accepted word visible on out_data/out_sel/out_valid one cycle after the accept edge.
- Throughput: one word per cycle while the addressed lanes are ready.
- No combinational path from in_data to out_*; in_ready depends combinationally on lane_ready and registered state only.

## Configuration
- LANE_SKIP_EN defined: skip-mode lane choice as above; a slow lane does not stall words that could go elsewhere.
- LANE_SKIP_EN undefined: strict round-robin; word n always goes to lane n mod 4; a stalled lane stalls the stream.

## Structure
- Shared package demux_lane_pkg: LANES=4, SEL_W=2, typedef lane_sel_t (logic [SEL_W-1:0]), function onehot4(lane_sel_t).
- One sub-module, lane_picker: combinational rotate-priority search (ptr, lane_ready -> chosen); instantiated only under LANE_SKIP_EN, otherwise chosen=ptr.

## Test plan
- Reset asserted mid-stream with out_valid=1 -> all outputs 0 asynchronously, word_count=0, first word after release goes to lane 0.
- lane_ready=4'hF, in_valid held, data 0x10..0x17 -> out_sel sequence 0,1,2,3,0,1,2,3, one word per cycle, word_count=8.
- Strict mode, lane_ready=4'b1101, send 0xA0,0xA1 -> 0xA0 on lane 0, 0xA1 held on lane 1 with in_ready=0 until lane_ready[1] rises, then drains next cycle.
- LANE_SKIP_EN, lane_ready=4'b1101, ptr=1, send 0xB0 -> out_sel=2, next word to lane 3.
- LANE_SKIP_EN, lane_ready=0, send 0xC0 at ptr=2 -> out_sel=2, held, in_ready=0; raise lane_ready[2] -> drains, new word accepted same cycle.
- CNT_W=4, accept 17 words -> word_count wraps to 1.
